// File: rtl/timer_pkg.sv
// Shared field widths, time constants and helpers for the timer-compare datapath.
package timer_pkg;

  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;
  localparam int unsigned SW = 6;
  localparam int unsigned TW = HW + MW + SW;

  localparam logic [TW-1:0] SEC_MASK = 17'h1FFC0;

  localparam logic [HW-1:0] HH_MAX = 5'd23;
  localparam logic [MW-1:0] MM_MAX = 6'd59;
  localparam logic [SW-1:0] SS_MAX = 6'd59;

  typedef struct packed {
    logic [HW-1:0] hh;
    logic [MW-1:0] mm;
    logic [SW-1:0] ss;
  } time_t;

  // True when every field of a packed time lies within its clock range.
  function automatic logic legal_time(input time_t t);
    return (t.hh <= HH_MAX) && (t.mm <= MM_MAX) && (t.ss <= SS_MAX);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// Saturating ring-duration counter: clears on request, counts ticks up to RING_LEN.
module ring_counter #(
  parameter int unsigned RING_LEN = 7,
  parameter int unsigned CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          at_max_c
);

  localparam logic [CW-1:0] TERM = CW'(RING_LEN);

  logic [CW-1:0] count_nxt;

  // Clear has priority over counting; the count never passes TERM.
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (tick && (count < TERM)) begin
      count_nxt = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign at_max_c = (count == TERM);

endmodule

// File: rtl/timer_compare_datapath.sv
// Datapath for the timer-compare controller: target/A/B/R registers, ring counter,
// and the Ts/c7/Az status returned to the controller.
module timer_compare_datapath
  import timer_pkg::*;
#(
  parameter int unsigned RING_LEN = 7,
  parameter int unsigned CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] time_now,
  input  logic          sec_tick,
  input  logic          set_valid,
  input  logic [TW-1:0] set_value,
  input  logic          cancel,
  input  logic [1:0]    s,
  input  logic          Kc,
  input  logic          La,
  input  logic          Lb,
  input  logic          Ea,
  input  logic          Lr,
  input  logic          Er,
  input  logic          Cc,
  input  logic          M,
  output logic          Ts,
  output logic          c7,
  output logic          Az,
  output logic          ring,
  output logic          timer_done,
  output logic [TW-1:0] a_out
);

  logic [TW-1:0] target_q, target_nxt;
  logic          ts_q, ts_nxt;
  logic [TW-1:0] a_q, a_nxt;
  logic [TW-1:0] b_q, b_nxt;
  logic [TW-1:0] r_q, r_nxt;
  logic          ring_q, ring_nxt;
  logic          done_q, done_nxt;

  logic          set_legal;
  logic [TW-1:0] cmp_mask;
  logic          az_int;
  logic          c7_int;
  logic [CW-1:0] ring_count;
  logic          unused_s0;

  assign set_legal = set_valid && legal_time(time_t'(set_value));
  assign cmp_mask  = s[1] ? SEC_MASK : {TW{1'b1}};
  assign az_int    = ((r_q & cmp_mask) == '0);
  assign unused_s0 = s[0];

  ring_counter #(
    .RING_LEN (RING_LEN),
    .CW       (CW)
  ) u_ring_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (Kc),
    .tick     (ring_q & sec_tick),
    .count    (ring_count),
    .at_max_c (c7_int)
  );

  // Next-state: a legal set beats cancel, which beats M, for the armed flag.
  always_comb begin
    target_nxt = target_q;
    ts_nxt     = ts_q;
    a_nxt      = a_q;
    b_nxt      = b_q;
    r_nxt      = r_q;
    ring_nxt   = 1'b0;
    done_nxt   = 1'b0;

    if (set_legal) begin
      target_nxt = set_value;
      ts_nxt     = 1'b1;
    end else if (cancel || M) begin
      ts_nxt = 1'b0;
    end

    if (La) a_nxt = time_now;
    if (Lb) b_nxt = target_q;

    if (Er) begin
      r_nxt = a_q ^ b_q;
    end else if (Lr) begin
      r_nxt = b_q;
    end else if (Cc) begin
      r_nxt = {TW{1'b1}};
    end

    ring_nxt = ts_q & az_int & ~c7_int & ~cancel & ~M;
    done_nxt = M & ts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      ts_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= {TW{1'b1}};
      ring_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      target_q <= target_nxt;
      ts_q     <= ts_nxt;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      r_q      <= r_nxt;
      ring_q   <= ring_nxt;
      done_q   <= done_nxt;
    end
  end

  assign Ts         = ts_q;
  assign ring       = ring_q;
  assign timer_done = done_q;
  assign Az         = az_int;
  assign c7         = c7_int;
  assign a_out      = Ea ? a_q : '0;

endmodule

// File: tb/tb_timer_compare_datapath.sv
// Directed scoreboard bench for timer_compare_datapath.
module tb_timer_compare_datapath;

  logic        clk;
  logic        rst_n;
  logic [16:0] time_now;
  logic        sec_tick;
  logic        set_valid;
  logic [16:0] set_value;
  logic        cancel;
  logic [1:0]  s;
  logic        Kc, La, Lb, Ea, Lr, Er, Cc, M;
  logic        Ts, c7, Az, ring, timer_done;
  logic [16:0] a_out;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  timer_compare_datapath #(.RING_LEN(7), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_now   (time_now),
    .sec_tick   (sec_tick),
    .set_valid  (set_valid),
    .set_value  (set_value),
    .cancel     (cancel),
    .s          (s),
    .Kc         (Kc),
    .La         (La),
    .Lb         (Lb),
    .Ea         (Ea),
    .Lr         (Lr),
    .Er         (Er),
    .Cc         (Cc),
    .M          (M),
    .Ts         (Ts),
    .c7         (c7),
    .Az         (Az),
    .ring       (ring),
    .timer_done (timer_done),
    .a_out      (a_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input int h, input int m, input int sec);
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    hh = 5'(h);
    mm = 6'(m);
    ss = 6'(sec);
    return {hh, mm, ss};
  endfunction

  task automatic push(input logic [16:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [16:0] obs);
    logic [16:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] t0, t0s5, t2;

  initial begin
    t0   = mk(7, 30, 0);
    t0s5 = mk(7, 30, 5);
    t2   = mk(8, 15, 20);

    rst_n = 1'b0; time_now = '0; sec_tick = 0; set_valid = 0; set_value = '0;
    cancel = 0; s = 2'b00; Kc = 0; La = 0; Lb = 0; Ea = 1; Lr = 0; Er = 0; Cc = 0; M = 0;

    // Reset state
    push(0); push(0); push(0); push(0); push(0); push(0);
    #12;
    chk("rst_ts", 17'(Ts)); chk("rst_ring", 17'(ring)); chk("rst_done", 17'(timer_done));
    chk("rst_az", 17'(Az)); chk("rst_c7", 17'(c7)); chk("rst_a_out", a_out);
    Ea = 0;
    rst_n = 1'b1;

    // Illegal sets (hh=24, then mm=60) are ignored
    set_valid = 1; set_value = mk(24, 30, 0); push(0); tick(); chk("illegal_hh_ts", 17'(Ts));
    set_value = mk(7, 60, 0); push(0); tick(); chk("illegal_mm_ts", 17'(Ts));
    set_valid = 0;
    Lb = 1; tick(); Lb = 0;
    Lr = 1; push(1); tick(); Lr = 0; chk("illegal_target_zero", 17'(Az));

    // Legal set, then load A and B
    set_valid = 1; set_value = t0; push(1); tick(); set_valid = 0; chk("legal_set_ts", 17'(Ts));
    time_now = t0; La = 1; Lb = 1; tick(); La = 0; Lb = 0;
    Ea = 1; push(t0); #1 chk("a_out_en", a_out);
    Ea = 0; push(0); #1 chk("a_out_dis", a_out);
    Lr = 1; push(0); tick(); Lr = 0; chk("lr_target_nonzero", 17'(Az));

    // Compare
    Er = 1; push(1); tick(); Er = 0; chk("cmp_equal", 17'(Az));
    time_now = t0s5; La = 1; tick(); La = 0;
    Er = 1; push(0); tick(); Er = 0; chk("cmp_secs_s00", 17'(Az));
    s = 2'b10; push(1); #1 chk("cmp_secs_s10", 17'(Az));
    s = 2'b11; push(1); #1 chk("cmp_s0_no_effect", 17'(Az));
    s = 2'b10;
    Cc = 1; push(0); tick(); Cc = 0; chk("cc_invalidate", 17'(Az));

    // Ring and saturating counter
    Er = 1; tick(); Er = 0;
    push(1); tick(); chk("ring_on", 17'(ring));
    sec_tick = 1;
    for (int i = 1; i <= 7; i++) begin
      push((i == 7) ? 17'd1 : 17'd0); push(1);
      tick();
      chk("c7_step", 17'(c7)); chk("ring_during_count", 17'(ring));
    end
    push(1); push(0); tick(); chk("c7_hold", 17'(c7)); chk("ring_off_after_c7", 17'(ring));
    push(1); tick(); chk("c7_saturate_a", 17'(c7));
    push(1); tick(); chk("c7_saturate_b", 17'(c7));
    Kc = 1; push(0); tick(); chk("kc_clear_with_tick", 17'(c7)); Kc = 0;
    sec_tick = 0;
    push(1); tick(); chk("ring_restart", 17'(ring));
    cancel = 1; push(0); push(0); tick(); cancel = 0;
    chk("cancel_ring", 17'(ring)); chk("cancel_ts", 17'(Ts));

    // Completion pulse
    set_valid = 1; set_value = t0; push(1); tick(); set_valid = 0; chk("rearm_ts", 17'(Ts));
    M = 1; push(1); push(0); tick(); M = 0;
    chk("m_done_pulse", 17'(timer_done)); chk("m_ts_clear", 17'(Ts));
    push(0); tick(); chk("m_done_one_cycle", 17'(timer_done));
    M = 1; push(0); tick(); M = 0; chk("m_no_ts_no_pulse", 17'(timer_done));

    // M with legal set keeps new target armed
    set_valid = 1; set_value = t0; tick();
    M = 1; set_value = t2; push(1); push(1); tick(); M = 0; set_valid = 0;
    chk("m_set_ts", 17'(Ts)); chk("m_set_done", 17'(timer_done));
    time_now = t2; La = 1; Lb = 1; tick(); La = 0; Lb = 0;
    s = 2'b00; Er = 1; push(1); tick(); Er = 0; chk("new_target_kept", 17'(Az));

    // Async reset in the middle of a ring
    push(1); tick(); chk("ring_before_reset", 17'(ring));
    sec_tick = 1; tick(); tick(); sec_tick = 0;
    #2 rst_n = 1'b0;
    push(0); push(0); push(0); push(0); push(0);
    #1;
    chk("arst_ring", 17'(ring)); chk("arst_ts", 17'(Ts)); chk("arst_done", 17'(timer_done));
    chk("arst_az", 17'(Az)); chk("arst_c7", 17'(c7));
    #3 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
